// File: rtl/account_tx_pkg.sv
// Shared types and constants for the account record transmitter: FSM encoding,
// run length, LFSR geometry and the polynomial step used by lfsr24.
package account_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int TOTAL_RECORDS = 4000;
  localparam int CNT_W         = 12;
  localparam int LFSR_W        = 24;

  // An all-zero LFSR would lock up, so a zero seed is replaced by this value.
  localparam logic [LFSR_W-1:0] ZERO_SEED_SUB = 24'h000001;

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] l);
    return {l[22:0], l[23] ^ l[22] ^ l[21] ^ l[16]};
  endfunction

endpackage

// File: rtl/account_tx_if.sv
// Record stream between the transmitter (master) and its sink (slave).
// A record moves on any rising edge where in_valid and ready are both high.
interface account_tx_if #(
  parameter int DSIZE = 8
) ();

  logic             in_valid;
  logic             ready;
  logic [DSIZE-1:0] in_account;
  logic [DSIZE-1:0] in_A;
  logic [DSIZE-1:0] in_T;

  modport master (
    output in_valid,
    output in_account,
    output in_A,
    output in_T,
    input  ready
  );

  modport slave (
    input  in_valid,
    input  in_account,
    input  in_A,
    input  in_T,
    output ready
  );

endinterface

// File: rtl/account_tx_lfsr24.sv
// 24-bit Fibonacci LFSR; load has priority over step, value is the register.
// One-cycle latency from load/step to value; no backpressure of its own.
module lfsr24
  import account_tx_pkg::*;
(
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              load,
  input  logic [LFSR_W-1:0] seed,
  input  logic              step,
  output logic [LFSR_W-1:0] value
);

  logic [LFSR_W-1:0] r_lfsr;

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr <= ZERO_SEED_SUB;
    end else if (load) begin
      r_lfsr <= seed;
    end else if (step) begin
      r_lfsr <= lfsr_step(r_lfsr);
    end
  end

  assign value = r_lfsr;

endmodule

// File: rtl/account_tx.sv
// Sends TOTAL pseudo-random records per run over a valid/ready stream, with an
// optional idle gap after each transfer; records and in_valid hold while ready is low.
module account_tx
  import account_tx_pkg::*;
#(
  parameter int DSIZE = 8,
  parameter int TOTAL = TOTAL_RECORDS
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LFSR_W-1:0] seed,
  input  logic [1:0]        gap,
  account_tx_if.master      bus,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  sent_cnt
);

  localparam logic [CNT_W-1:0] TOTAL_C = CNT_W'(TOTAL);

  state_t            r_state;
  logic              r_in_valid;
  logic [LFSR_W-1:0] r_rec;
  logic              r_busy;
  logic              r_done;
  logic [CNT_W-1:0]  r_sent_cnt;
  logic [1:0]        r_gap;
  logic [1:0]        r_gap_cnt;

  state_t            w_state_nxt;
  logic              w_in_valid_nxt;
  logic [LFSR_W-1:0] w_rec_nxt;
  logic              w_busy_nxt;
  logic              w_done_nxt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [1:0]        w_gap_nxt;
  logic [1:0]        w_gap_cnt_nxt;
  logic              w_load;
  logic              w_step;
  logic              w_xfer;
  logic [CNT_W-1:0]  w_cnt_inc;
  logic [LFSR_W-1:0] w_seed_eff;
  logic [LFSR_W-1:0] w_lfsr;

  assign w_seed_eff = (seed == '0) ? ZERO_SEED_SUB : seed;
  assign w_xfer     = r_in_valid & bus.ready;
  assign w_cnt_inc  = r_sent_cnt + 1'b1;

  lfsr24 u_lfsr (
    .clk1  (clk1),
    .rst_n (rst_n),
    .load  (w_load),
    .seed  (w_seed_eff),
    .step  (w_step),
    .value (w_lfsr)
  );

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // The record register always holds the LFSR value that will be presented next
  // cycle, so the outputs stay registered while still tracking the stepped LFSR.
  always_comb begin
    w_state_nxt    = r_state;
    w_in_valid_nxt = r_in_valid;
    w_rec_nxt      = r_rec;
    w_busy_nxt     = r_busy;
    w_done_nxt     = 1'b0;
    w_cnt_nxt      = r_sent_cnt;
    w_gap_nxt      = r_gap;
    w_gap_cnt_nxt  = r_gap_cnt;
    w_load         = 1'b0;
    w_step         = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt    = ST_SEND;
          w_in_valid_nxt = 1'b1;
          w_rec_nxt      = w_seed_eff;
          w_busy_nxt     = 1'b1;
          w_cnt_nxt      = '0;
          w_gap_nxt      = gap;
          w_load         = 1'b1;
        end
      end

      ST_SEND: begin
        if (w_xfer) begin
          w_step    = 1'b1;
          w_cnt_nxt = w_cnt_inc;
          if (w_cnt_inc == TOTAL_C) begin
            w_state_nxt    = ST_DONE;
            w_in_valid_nxt = 1'b0;
            w_rec_nxt      = '0;
            w_done_nxt     = 1'b1;
          end else if (r_gap == 2'd0) begin
            w_rec_nxt = lfsr_step(w_lfsr);
          end else begin
            w_state_nxt    = ST_GAP;
            w_in_valid_nxt = 1'b0;
            w_rec_nxt      = '0;
            w_gap_cnt_nxt  = r_gap - 2'd1;
          end
        end
      end

      ST_GAP: begin
        if (r_gap_cnt == 2'd0) begin
          w_state_nxt    = ST_SEND;
          w_in_valid_nxt = 1'b1;
          w_rec_nxt      = w_lfsr;
        end else begin
          w_gap_cnt_nxt = r_gap_cnt - 2'd1;
        end
      end

      ST_DONE: begin
        w_state_nxt = ST_IDLE;
        w_busy_nxt  = 1'b0;
      end

      default: begin
        w_state_nxt    = ST_IDLE;
        w_in_valid_nxt = 1'b0;
        w_rec_nxt      = '0;
        w_busy_nxt     = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      r_in_valid <= 1'b0;
      r_rec      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_sent_cnt <= '0;
      r_gap      <= '0;
      r_gap_cnt  <= '0;
    end else begin
      r_in_valid <= w_in_valid_nxt;
      r_rec      <= w_rec_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_sent_cnt <= w_cnt_nxt;
      r_gap      <= w_gap_nxt;
      r_gap_cnt  <= w_gap_cnt_nxt;
    end
  end

  assign bus.in_valid   = r_in_valid;
  assign bus.in_account = DSIZE'(r_rec[7:0]);
  assign bus.in_A       = DSIZE'(r_rec[15:8]);
  assign bus.in_T       = DSIZE'(r_rec[23:16]);
  assign busy           = r_busy;
  assign done           = r_done;
  assign sent_cnt       = r_sent_cnt;

endmodule
